// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    // Bubble instruction presented to decode when valid=0
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0);

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    // Fetched word paired with the PC+4 handed to decode
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_next;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load has priority over bubble; hold freezes everything.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic               hold,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (!hold) begin
            if (load) begin
                instr_d = instr_in;
                pc_d    = pc_in;
                valid_d = 1'b1;
            end else if (bubble) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pc_out      = pc_q;
    assign valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ready memory handshake, freeze hold buffer,
// branch redirect with squash of the wrong-path fetch, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_offset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    fetch_pkt_t        hold_buf_q, hold_buf_d;
    logic              imem_req_q, imem_req_d;

    logic              ifid_load, ifid_bubble, ifid_hold;
    fetch_pkt_t        ifid_pkt;

    logic              br_accept;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] seq_addr;

    // A branch only counts for a real, non-stalled instruction in IF/ID
    assign br_accept = br_taken && valid && !freeze;
    assign br_target = pc_out + (br_offset << 2);
    assign seq_addr  = req_addr_q + ADDR_W'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        redirect_d  = redirect_q;
        hold_buf_d  = hold_buf_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_hold   = 1'b0;
        ifid_pkt    = '{instr: imem_rdata, pc_next: seq_addr};

        case (state_q)
            START: begin
                req_addr_d = pc_q;
                ifid_hold  = 1'b1;
                state_d    = FETCH;
            end
            FETCH: begin
                if (br_accept) begin
                    ifid_bubble = 1'b1;
                    if (imem_ready) begin
                        pc_d       = br_target;
                        req_addr_d = br_target;
                    end else begin
                        redirect_d = br_target;
                        state_d    = DISCARD;
                    end
                end else if (imem_ready) begin
                    if (freeze) begin
                        hold_buf_d = '{instr: imem_rdata, pc_next: seq_addr};
                        ifid_hold  = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        pc_d       = seq_addr;
                        req_addr_d = seq_addr;
                    end
                end else if (freeze) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (freeze) begin
                    ifid_hold = 1'b1;
                end else if (br_accept) begin
                    ifid_bubble = 1'b1;
                    pc_d        = br_target;
                    req_addr_d  = br_target;
                    state_d     = FETCH;
                end else begin
                    ifid_load  = 1'b1;
                    ifid_pkt   = hold_buf_q;
                    pc_d       = seq_addr;
                    req_addr_d = seq_addr;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                // Squashed request must still complete before the redirect is issued
                ifid_hold   = freeze;
                ifid_bubble = !freeze;
                if (imem_ready) begin
                    pc_d       = redirect_q;
                    req_addr_d = redirect_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = START;
            end
        endcase

        imem_req_d = (state_d == FETCH) || (state_d == DISCARD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            redirect_q <= '0;
            hold_buf_q <= '0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            redirect_q <= redirect_d;
            hold_buf_q <= hold_buf_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;

    if_id_reg u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .hold        (ifid_hold),
        .instr_in    (ifid_pkt.instr),
        .pc_in       (ifid_pkt.pc_next),
        .instruction (instruction),
        .pc_out      (pc_out),
        .valid       (valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It holds the PC and issues word fetches to instruction memory over a req/ready handshake. Each returned instruction and its PC+4 are presented to decode. The block stalls on the hazard freeze, redirects on taken branches resolved in decode, and squashes the wrong-path instruction; there is no delay slot.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- freeze  in  1  hazard stall; IF/ID outputs and PC hold.
- br_taken  in  1  decode reports the current IF/ID instruction's branch as taken.
- br_offset  in  32  sign-extended 16-bit branch immediate, word units.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address, word aligned.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- instruction  out  32  IF/ID instruction register.
- pc_out  out  32  IF/ID PC+4 of that instruction.
- valid  out  1  IF/ID holds a real instruction; 0 = bubble (decode treats it as NOP).

## Operation
- Registers:
  - pc: address of the next fetch.
  - req_addr: address of the outstanding request.
  - redirect: pending branch target.
  - hold_buf: fetched instruction plus its PC+4.
  - IF/ID: instruction, pc_out, valid.
- The branch is accepted only when br_taken=1, valid=1 and freeze=0.
- target = pc_out + (br_offset << 2), modulo 2^32.
- FSM states: START, FETCH, HOLD, DISCARD.
- START (reset state):
  - imem_req=0.
  - Next cycle goes to FETCH with req_addr=pc.
- FETCH: imem_req=1, imem_addr=req_addr. req_addr stays stable until imem_ready=1.
  - Accepted branch with ready=1: drop the data, valid<=0, pc<=req_addr<=target, stay in FETCH.
  - Accepted branch with ready=0: redirect<=target, valid<=0, go to DISCARD.
  - ready=1, freeze=0: IF/ID <= {imem_rdata, req_addr+4, valid=1}; pc and req_addr advance by 4.
  - ready=1, freeze=1: hold_buf <= {imem_rdata, req_addr+4}; IF/ID unchanged; go to HOLD.
  - ready=0, freeze=0: valid<=0 (bubble).
  - ready=0, freeze=1: IF/ID unchanged.
- HOLD: imem_req=0.
  - Stays in HOLD while freeze=1.
  - freeze=0 with an accepted branch: hold_buf dropped, valid<=0, pc<=req_addr<=target, go to FETCH.
  - freeze=0, no branch: IF/ID <= hold_buf with valid=1; pc and req_addr advance by 4; go to FETCH.
- DISCARD: imem_req=1 on the old req_addr.
  - On ready=1: data dropped, pc<=req_addr<=redirect, go to FETCH.
  - IF/ID keeps valid=0 unless freeze=1; under freeze, IF/ID holds.
  - Any further br_taken is ignored because valid=0.
- freeze never blocks the memory handshake. An outstanding request always completes.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - instruction=0, pc_out=0, valid=0.
  - pc=req_addr=RESET_PC, redirect=0, state START.
- Reset asserted mid-request abandons the request immediately. Memory must tolerate the dropped request.
- First request is asserted the first cycle after rst deasserts (the START cycle) + 1.
- Zero-wait memory (ready tied 1): one instruction per cycle. Data fetched at cycle n is visible on IF/ID at cycle n+1.
- Branch penalty: exactly 1 bubble with zero-wait memory. With wait states, 1 bubble + the remaining wait cycles of the squashed request.
- imem_req and imem_addr are functions of state/req_addr only. There is no combinational path from the inputs to imem_*.
- br_offset and br_taken → next-state/target is a combinational path. The clk constraint covers the adder.
- PC wraps at 32'hFFFF_FFFC → 0 with no flag.

## Structure
- Shared package: fetch state encoding (START, FETCH, HOLD, DISCARD), the NOP/bubble instruction constant 32'h0, and INSTR_W=32.
- One sub-module: if_id_reg.
  - Ports: instruction, pc_out, valid.
  - Controls: load, bubble, hold.
  - Async active-low reset.
- FSM, PC and hold_buf live in fetch_stage.

## Test plan
- Reset, ready=1, no branch: imem_addr 0,4,8,… on consecutive cycles; pc_out 4,8,… one cycle later; valid=1 from the first return.
- ready low 2 cycles per request: imem_addr stable for 3 cycles; valid=0 for 2 cycles, then 1.
- freeze=1 for 3 cycles when ready=1 at addr 0x10: IF/ID holds; imem_req=0 in HOLD; after release, instruction from 0x10 appears with pc_out=0x14 and the next fetch is 0x14.
- pc_out=0x24, br_offset=-3, br_taken, ready=1: next valid=0; next imem_addr=0x18.
- Same branch while ready=0 on 0x28 with 2 wait cycles: 0x28 held until ready; its data never appears; next fetch 0x18.
- br_taken with valid=0 or freeze=1: ignored; sequential fetch continues.
- rst low mid-request: all outputs return to reset values asynchronously; refetch starts at RESET_PC.
